// File: rtl/exibe_sequencia.sv
// rtl/exibe_sequencia.sv - sequence display FSM: lights each sequence memory element for T_ON cycles, then T_OFF dark cycles.
// Optional: define EXIBE_SEQUENCIA_DB_ESTADO_EN to drive db_estado with the current state code.
module exibe_sequencia #(
  parameter int unsigned T_ON  = 1000,
  parameter int unsigned T_OFF = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] dado,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ativo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    ACENDE  = 4'd2,
    APAGA   = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  localparam logic [15:0] ON_LAST  = 16'(T_ON - 1);
  localparam logic [15:0] OFF_LAST = 16'(T_OFF - 1);

  estado_t     estado, estado_n;
  logic [15:0] timer, timer_n;
  logic [3:0]  lim_r, lim_n;
  logic [3:0]  endereco_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= INICIAL;
      timer    <= 16'd0;
      lim_r    <= 4'd0;
      endereco <= 4'd0;
    end else begin
      estado   <= estado_n;
      timer    <= timer_n;
      lim_r    <= lim_n;
      endereco <= endereco_n;
    end
  end

  always_comb begin
    estado_n   = INICIAL;
    timer_n    = timer;
    lim_n      = lim_r;
    endereco_n = endereco;
    leds       = 4'd0;
    ativo      = 1'b0;
    pronto     = 1'b0;
    case (estado)
      INICIAL: begin
        if (iniciar) begin
          lim_n    = limite;
          estado_n = PREPARA;
        end else begin
          estado_n = INICIAL;
        end
      end
      PREPARA: begin
        ativo      = 1'b1;
        endereco_n = 4'd0;
        timer_n    = 16'd0;
        estado_n   = ACENDE;
      end
      ACENDE: begin
        ativo = 1'b1;
        leds  = dado;
        if (timer == ON_LAST) begin
          timer_n  = 16'd0;
          estado_n = APAGA;
        end else begin
          timer_n  = timer + 16'd1;
          estado_n = ACENDE;
        end
      end
      APAGA: begin
        ativo = 1'b1;
        if (timer == OFF_LAST) begin
          timer_n  = 16'd0;
          estado_n = (endereco == lim_r) ? FIM : PROXIMO;
        end else begin
          timer_n  = timer + 16'd1;
          estado_n = APAGA;
        end
      end
      PROXIMO: begin
        ativo      = 1'b1;
        endereco_n = endereco + 4'd1;
        estado_n   = ACENDE;
      end
      FIM: begin
        // endereco keeps the last shown address until the next PREPARA
        pronto   = 1'b1;
        estado_n = INICIAL;
      end
      default: estado_n = INICIAL;
    endcase
  end

`ifdef EXIBE_SEQUENCIA_DB_ESTADO_EN
  assign db_estado = estado;
`else
  assign db_estado = 4'd0;
`endif

endmodule
